dqs_preamble_tracker: RTL and testbench
=======================================

Name: dqs_preamble_tracker

Overview:
- Multi-lane, parametrised successor of the single-lane DQS preamble detector in the read data manager.
- Each lane searches its DQS sample stream for the programmed DDR5 read preamble and pulses on detection.
- After a detection, each lane holds a lock window for the read burst, then re-arms.
- Adds a fill-count guard against false matches, a per-lane search timeout, and an all-lanes-locked indication for read-data capture alignment.

Parameters:
- NUM_LANES, 2, number of independent DQS lanes.
- MAX_PAT_LEN, 8, shift-register depth per lane; legal range 8..16.
- TIMEOUT_W, 8, width of the timeout counter and of timeout_i.
- BL_W, 5, width of the burst counter and of burst_len_i.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- en_i  in  1  block enable, active high.
- dqs_i  in  NUM_LANES  sampled DQS level, one bit per lane.
- pre_amble_sett_i  in  3  preamble select.
- timeout_i  in  TIMEOUT_W  search timeout in cycles; 0 disables the timeout.
- burst_len_i  in  BL_W  lock window length in cycles; 0 is treated as 1.
- pattern_detected_o  out  NUM_LANES  per-lane single-cycle detection pulse.
- lock_o  out  NUM_LANES  per-lane level, high during the lock window.
- timeout_o  out  NUM_LANES  per-lane single-cycle timeout pulse.
- all_locked_o  out  1  AND of all lock_o bits.

Behaviour:
- Reset (reset_n_i=0 at a clock edge): all lanes go to IDLE; shift registers, fill, timeout and burst counters clear to 0; every output is 0.
- en_i=0 overrides everything: same clearing as reset, taking effect on the next edge, including mid-lock or mid-search.
- Pattern table (first-received bit leftmost):
  - 000: "10", length 2.
  - 001: "0010", length 4.
  - 010: "1110", length 4.
  - 011: "000010", length 6.
  - 100: "00001010", length 8.
  - 101, 110, 111: fall back to "10", length 2.
- pre_amble_sett_i is latched once, on the IDLE->SEARCH transition. Later changes are ignored until en_i is deasserted.
- Per-lane FSM states: IDLE, SEARCH, LOCK.
- IDLE:
  - Moves to SEARCH on the next edge when en_i=1.
  - Clears the shift register, fill count and timeout counter.
- SEARCH, every cycle:
  - Shift: sr <= {sr[MAX_PAT_LEN-2:0], dqs_i[lane]}.
  - fill increments, saturating at MAX_PAT_LEN.
  - Match is evaluated combinationally on the window {sr, dqs_i[lane]}, i.e. the newest N bits including the current sample.
  - A match counts only when fill+1 >= N; zero history can never complete a pattern.
  - On match: go to LOCK and load the burst counter with max(burst_len_i,1).
  - Timeout: the counter increments each SEARCH cycle. When it reaches timeout_i (nonzero) with no match, pulse timeout_o for 1 cycle, clear the timeout counter, and stay in SEARCH. The shift register and fill count are kept.
  - Match and timeout in the same cycle: the match wins and no timeout pulse is issued.
- Detection latency:
  - The last pattern bit is sampled in cycle t.
  - pattern_detected_o[lane]=1 in cycle t+1 only.
  - lock_o[lane]=1 for cycles t+1 .. t+burst_len.
- LOCK:
  - dqs_i is ignored.
  - The burst counter decrements each cycle.
  - When the counter reaches its last cycle, the lane returns to SEARCH with sr, fill and timeout counter cleared; sampling resumes in cycle t+burst_len+1.
- Lanes are fully independent. all_locked_o is the registered-output AND of lock_o and has no extra latency relative to lock_o.
- Width rules:
  - Counters wrap never; the timeout counter is cleared at its terminal count.
  - Any comparison using N > MAX_PAT_LEN is impossible by table construction.

Optional Feature:
- Macro: DQS_CUSTOM_PATTERN_EN.
- When defined:
  - Adds input cfg_pattern_i (MAX_PAT_LEN bits, right-aligned, first bit at index cfg_len_i-1).
  - Adds input cfg_len_i ($clog2(MAX_PAT_LEN)+1 bits, legal 2..MAX_PAT_LEN).
  - Setting 111 selects the custom pattern; both inputs are latched together with pre_amble_sett_i.
  - cfg_len_i values outside the legal range fall back to "10".
- When undefined: these ports do not exist and 111 falls back to "10".

Test Plan:
- Reset/enable: reset_n_i=0 for 2 cycles with en_i=1 and dqs_i toggling -> all outputs 0; release with en_i=0 -> outputs remain 0.
- Setting 001, lane0 stream 0,0,1,0 starting in the first SEARCH cycle, burst_len_i=4 -> pattern_detected_o[0]=1 exactly one cycle after the 4th sample; lock_o[0] high 4 cycles; lane1 untouched.
- False-match guard, setting 011: first SEARCH samples 1,0 -> no detection (fill<6); then 0,0,0,0,1,0 -> detection one cycle after the last 0.
- Timeout: timeout_i=5, lane1 constant 1, setting 000 -> timeout_o[1] pulses every 5 SEARCH cycles, no detection; a match landing on the 5th cycle -> detection and no timeout pulse.
- Both lanes, setting 100, lane1 pattern 2 cycles after lane0, burst_len_i=6 -> all_locked_o high for 4 cycles; en_i dropped mid-lock -> all outputs 0 on the next edge.
- With DQS_CUSTOM_PATTERN_EN: setting 111, cfg_pattern_i=0b110011, cfg_len_i=6 -> detection after 1,1,0,0,1,1; cfg_len_i=1 -> behaves as "10".

Source files
------------

// File: rtl/dqs_preamble_tracker_if.sv
// DQS preamble tracker bus: configuration and DQS samples in, per-lane status out.
// Build option DQS_CUSTOM_PATTERN_EN adds the programmable pattern inputs.
interface dqs_preamble_tracker_if #(
  parameter int NUM_LANES   = 2,
  parameter int MAX_PAT_LEN = 8,
  parameter int TIMEOUT_W   = 8,
  parameter int BL_W        = 5
);
  localparam int CFG_LEN_W = $clog2(MAX_PAT_LEN) + 1;

  logic                 en_i;
  logic [NUM_LANES-1:0] dqs_i;
  logic [2:0]           pre_amble_sett_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic [BL_W-1:0]      burst_len_i;
`ifdef DQS_CUSTOM_PATTERN_EN
  logic [MAX_PAT_LEN-1:0] cfg_pattern_i;
  logic [CFG_LEN_W-1:0]   cfg_len_i;
`endif
  logic [NUM_LANES-1:0] pattern_detected_o;
  logic [NUM_LANES-1:0] lock_o;
  logic [NUM_LANES-1:0] timeout_o;
  logic                 all_locked_o;

  modport master (
`ifdef DQS_CUSTOM_PATTERN_EN
    output cfg_pattern_i, cfg_len_i,
`endif
    output en_i, dqs_i, pre_amble_sett_i, timeout_i, burst_len_i,
    input  pattern_detected_o, lock_o, timeout_o, all_locked_o
  );

  modport slave (
`ifdef DQS_CUSTOM_PATTERN_EN
    input  cfg_pattern_i, cfg_len_i,
`endif
    input  en_i, dqs_i, pre_amble_sett_i, timeout_i, burst_len_i,
    output pattern_detected_o, lock_o, timeout_o, all_locked_o
  );
endinterface

// File: rtl/dqs_preamble_tracker.sv
// Multi-lane DDR5 read-preamble detector: per-lane search/lock FSM with fill guard and timeout.
// Define DQS_CUSTOM_PATTERN_EN to let setting 111 select a programmable pattern.
module dqs_preamble_tracker #(
  parameter int NUM_LANES   = 2,
  parameter int MAX_PAT_LEN = 8,
  parameter int TIMEOUT_W   = 8,
  parameter int BL_W        = 5
) (
  input logic clk_i,
  input logic reset_n_i,
  dqs_preamble_tracker_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_PAT_LEN) + 1;
  localparam int FILL_W = $clog2(MAX_PAT_LEN + 1);
  localparam int WIN_W  = MAX_PAT_LEN + 1;
  localparam int TW1    = TIMEOUT_W + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_e;

  logic                   clr;
  logic                   armed_q;
  logic [MAX_PAT_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [WIN_W-1:0]       mask;
  logic [NUM_LANES-1:0]   det_v, lock_v, tmo_v;

  assign clr = !reset_n_i || !bus.en_i;

  // Pattern stored right-aligned with the first-received bit at index len-1.
  always_comb begin
    pat_d = MAX_PAT_LEN'(2'b10);
    len_d = LEN_W'(2);
    case (bus.pre_amble_sett_i)
      3'b001: begin pat_d = MAX_PAT_LEN'(4'b0010);     len_d = LEN_W'(4); end
      3'b010: begin pat_d = MAX_PAT_LEN'(4'b1110);     len_d = LEN_W'(4); end
      3'b011: begin pat_d = MAX_PAT_LEN'(6'b000010);   len_d = LEN_W'(6); end
      3'b100: begin pat_d = MAX_PAT_LEN'(8'b00001010); len_d = LEN_W'(8); end
`ifdef DQS_CUSTOM_PATTERN_EN
      3'b111: begin
        if (bus.cfg_len_i >= LEN_W'(2) && bus.cfg_len_i <= LEN_W'(MAX_PAT_LEN)) begin
          pat_d = bus.cfg_pattern_i &
                  ((MAX_PAT_LEN'(1) << bus.cfg_len_i) - MAX_PAT_LEN'(1));
          len_d = bus.cfg_len_i;
        end
      end
`endif
      default: ;
    endcase
  end

  // Latched on the IDLE->SEARCH step shared by all lanes; held until en_i drops.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      armed_q <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
    end else if (!armed_q) begin
      armed_q <= 1'b1;
      pat_q   <= pat_d;
      len_q   <= len_d;
    end
  end

  assign mask = (WIN_W'(1) << len_q) - WIN_W'(1);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    state_e                 state_q, state_d;
    logic [MAX_PAT_LEN-1:0] sr_q, sr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [TIMEOUT_W-1:0]   to_q, to_d;
    logic [BL_W-1:0]        bl_q, bl_d;
    logic                   det_q, det_d, tmo_q, tmo_d;
    logic [WIN_W-1:0]       win;
    logic                   fill_ok, match, to_hit, lock_l;

    assign win     = {sr_q, bus.dqs_i[g]};
    assign fill_ok = (int'(fill_q) + 1) >= int'(len_q);
    assign match   = fill_ok && (((win ^ {1'b0, pat_q}) & mask) == '0);
    assign to_hit  = (bus.timeout_i != '0) &&
                     (({1'b0, to_q} + TW1'(1)) >= {1'b0, bus.timeout_i});

    always_ff @(posedge clk_i) begin
      if (clr) begin
        state_q <= IDLE;
        sr_q    <= '0;
        fill_q  <= '0;
        to_q    <= '0;
        bl_q    <= '0;
        det_q   <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sr_q    <= sr_d;
        fill_q  <= fill_d;
        to_q    <= to_d;
        bl_q    <= bl_d;
        det_q   <= det_d;
        tmo_q   <= tmo_d;
      end
    end

    always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      fill_d  = fill_q;
      to_d    = to_q;
      bl_d    = bl_q;
      det_d   = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
        IDLE: begin
          sr_d    = '0;
          fill_d  = '0;
          to_d    = '0;
          bl_d    = '0;
          state_d = SEARCH;
        end
        SEARCH: begin
          sr_d   = win[MAX_PAT_LEN-1:0];
          fill_d = (fill_q == FILL_W'(MAX_PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
          to_d   = to_q + TIMEOUT_W'(1);
          if (match) begin
            state_d = LOCK;
            det_d   = 1'b1;
            bl_d    = (bus.burst_len_i == '0) ? BL_W'(1) : bus.burst_len_i;
          end else if (to_hit) begin
            tmo_d = 1'b1;
            to_d  = '0;
          end
        end
        LOCK: begin
          if (bl_q <= BL_W'(1)) begin
            state_d = SEARCH;
            sr_d    = '0;
            fill_d  = '0;
            to_d    = '0;
            bl_d    = '0;
          end else begin
            bl_d = bl_q - BL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      lock_l = (state_q == LOCK);
    end

    assign det_v[g]  = det_q;
    assign tmo_v[g]  = tmo_q;
    assign lock_v[g] = lock_l;
  end

  assign bus.pattern_detected_o = det_v;
  assign bus.timeout_o          = tmo_v;
  assign bus.lock_o             = lock_v;
  assign bus.all_locked_o       = &lock_v;
endmodule

// File: tb/tb_dqs_preamble_tracker.sv
// Directed bench for dqs_preamble_tracker: reset/enable, preamble table, fill guard,
// timeout, multi-lane lock overlap and (when built with it) the custom pattern option.
module tb_dqs_preamble_tracker;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  dqs_preamble_tracker_if #(.NUM_LANES(2), .MAX_PAT_LEN(8), .TIMEOUT_W(8), .BL_W(5)) bus ();

  dqs_preamble_tracker #(.NUM_LANES(2), .MAX_PAT_LEN(8), .TIMEOUT_W(8), .BL_W(5)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.all_locked_o, bus.timeout_o, bus.lock_o, bus.pattern_detected_o};
  endfunction

  logic [3:0] p4;
  logic [7:0] s8;
  logic [9:0] l0, l1;
  logic [4:0] s5;
  logic [5:0] s6;

  initial begin
    rst_n                = 1'b0;
    bus.en_i             = 1'b1;
    bus.dqs_i            = 2'b00;
    bus.pre_amble_sett_i = 3'b000;
    bus.timeout_i        = 8'd0;
    bus.burst_len_i      = 5'd4;
`ifdef DQS_CUSTOM_PATTERN_EN
    bus.cfg_pattern_i    = 8'h00;
    bus.cfg_len_i        = 4'd0;
`endif

    // Reset held with en_i=1 and toggling DQS, then released with en_i=0.
    for (int i = 0; i < 2; i++) begin
      bus.dqs_i = ~bus.dqs_i;
      tick();
      check("reset_outs", 32'(outs()), 32'd0);
    end
    rst_n    = 1'b1;
    bus.en_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.dqs_i = ~bus.dqs_i;
      tick();
      check("en0_outs", 32'(outs()), 32'd0);
    end

    // Setting 001 "0010" on lane0, burst 4.
    bus.dqs_i = 2'b00; bus.pre_amble_sett_i = 3'b001; bus.burst_len_i = 5'd4; bus.en_i = 1'b1;
    tick();
    p4 = 4'b0010;
    for (int i = 3; i >= 0; i--) begin
      bus.dqs_i = {1'b0, p4[i]};
      tick();
      if (i > 0) check("p001_early_det", 32'(bus.pattern_detected_o), 32'd0);
    end
    check("p001_det", 32'(bus.pattern_detected_o), 32'd1);
    check("p001_lock_first", 32'(bus.lock_o), 32'd1);
    bus.dqs_i = 2'b00;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("p001_lock_hold", 32'(bus.lock_o), 32'd1);
      check("p001_det_single", 32'(bus.pattern_detected_o), 32'd0);
    end
    tick();
    check("p001_lock_end", 32'(bus.lock_o), 32'd0);
    check("p001_no_timeout", 32'(bus.timeout_o), 32'd0);
    bus.en_i = 1'b0;
    tick();

    // Setting 011 "000010": short history must not complete the pattern.
    bus.pre_amble_sett_i = 3'b011; bus.en_i = 1'b1;
    tick();
    s8 = 8'b1000_0010;
    for (int i = 7; i >= 0; i--) begin
      bus.dqs_i = {1'b0, s8[i]};
      tick();
      if (i > 0) check("p011_guard", 32'(bus.pattern_detected_o), 32'd0);
    end
    check("p011_det", 32'(bus.pattern_detected_o), 32'd1);
    bus.en_i = 1'b0;
    tick();

    // Timeout every 5 search cycles on both idle-pattern lanes.
    bus.pre_amble_sett_i = 3'b000; bus.timeout_i = 8'd5; bus.dqs_i = 2'b10; bus.en_i = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("tmo_pulse", 32'(bus.timeout_o), (k % 5 == 0) ? 32'd3 : 32'd0);
      check("tmo_no_det", 32'(bus.pattern_detected_o), 32'd0);
    end
    bus.en_i = 1'b0;
    tick();

    // Match on the 5th search cycle beats timeout; setting change mid-search ignored; burst 0 -> 1.
    bus.burst_len_i = 5'd0; bus.dqs_i = 2'b10; bus.en_i = 1'b1;
    tick();
    bus.pre_amble_sett_i = 3'b011;
    s5 = 5'b00010;
    for (int i = 4; i >= 0; i--) begin
      bus.dqs_i = {1'b1, s5[i]};
      tick();
    end
    check("race_det", 32'(bus.pattern_detected_o), 32'd1);
    check("race_tmo", 32'(bus.timeout_o), 32'd2);
    check("bl0_lock", 32'(bus.lock_o), 32'd1);
    tick();
    check("bl0_lock_end", 32'(bus.lock_o), 32'd0);
    bus.en_i = 1'b0;
    tick();

    // Setting 100, lane1 two cycles behind lane0, burst 6; drop en_i while lane1 locked.
    bus.pre_amble_sett_i = 3'b100; bus.burst_len_i = 5'd6; bus.timeout_i = 8'd0;
    bus.dqs_i = 2'b00; bus.en_i = 1'b1;
    tick();
    l0 = 10'h050;
    l1 = 10'h140;
    for (int c = 1; c <= 14; c++) begin
      bus.dqs_i = (c <= 10) ? {l1[c-1], l0[c-1]} : 2'b00;
      tick();
      check("dual_all_locked", 32'(bus.all_locked_o), (c + 1 >= 11 && c + 1 <= 14) ? 32'd1 : 32'd0);
      check("dual_lock", 32'(bus.lock_o),
            {30'd0, (c + 1 >= 11 && c + 1 <= 16), (c + 1 >= 9 && c + 1 <= 14)});
      check("dual_det", 32'(bus.pattern_detected_o), {30'd0, (c + 1 == 11), (c + 1 == 9)});
    end
    bus.en_i = 1'b0;
    tick();
    check("en_drop_outs", 32'(outs()), 32'd0);

`ifdef DQS_CUSTOM_PATTERN_EN
    // Custom "110011", then an illegal length falling back to "10".
    bus.pre_amble_sett_i = 3'b111; bus.cfg_pattern_i = 8'b0011_0011; bus.cfg_len_i = 4'd6;
    bus.burst_len_i = 5'd1; bus.en_i = 1'b1;
    tick();
    s6 = 6'b110011;
    for (int i = 5; i >= 0; i--) begin
      bus.dqs_i = {1'b0, s6[i]};
      tick();
      if (i > 0) check("cust_early", 32'(bus.pattern_detected_o), 32'd0);
    end
    check("cust_det", 32'(bus.pattern_detected_o), 32'd1);
    bus.en_i = 1'b0;
    tick();
    bus.cfg_len_i = 4'd1; bus.dqs_i = 2'b00; bus.en_i = 1'b1;
    tick();
    bus.dqs_i = 2'b01;
    tick();
    check("cust_bad_len_early", 32'(bus.pattern_detected_o), 32'd0);
    bus.dqs_i = 2'b00;
    tick();
    check("cust_bad_len_det", 32'(bus.pattern_detected_o), 32'd1);
`else
    // Setting 111 falls back to "10".
    s6 = 6'b000000;
    bus.pre_amble_sett_i = 3'b111; bus.burst_len_i = 5'd1; bus.dqs_i = s6[1:0]; bus.en_i = 1'b1;
    tick();
    bus.dqs_i = 2'b01;
    tick();
    check("p111_early", 32'(bus.pattern_detected_o), 32'd0);
    bus.dqs_i = 2'b00;
    tick();
    check("p111_det", 32'(bus.pattern_detected_o), 32'd1);
`endif
    bus.en_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
